// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch definitions: FIFO entry layout, FSM encodings, default FIFO depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_ctrl_pkg;

  // One buffered fetch: the PC it came from plus the instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: memory address/data, redirect request, decode handshake, fault flag.
// Latency: n/a (wires only).
// Backpressure: out_ready from decode stalls the head entry.
interface instr_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  // master: the fetch controller; slave: memory + redirect source + decode.
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault,
    input  imem_rd, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault,
    output imem_rd, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Generic DEPTH x entry_t synchronous FIFO with push/pop/flush; flush beats push and pop.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
// Ports: clk/rst_n, push_i/push_dat_i, pop_i, flush_i, count_o, head_vld_o/head_dat_o.
module instr_fetch_ctrl_fifo
  import instr_fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  entry_t        push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          head_vld_o,
  output entry_t        head_dat_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // Cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count_o    = count_q;
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads combinational imem, buffers {pc,instr} into a skid FIFO.
// Latency: PC presented in cycle N is at the FIFO head in cycle N+1; redirect target in N+2.
// Backpressure: out_ready=0 fills the FIFO, then the PC freezes; no bubble on release.
// Ports: clk, rst_n, bus (master): imem_addr/imem_rd, redirect_*, out_* handshake, fault.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          DEPTH      = DEFAULT_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_ctrl_if.master bus
);

  localparam int          CW        = $clog2(DEPTH + 1);
  // Kept at 33 bits so a 2^30-word memory does not overflow the bound.
  localparam logic [32:0] PC_LIMIT  = 33'(IMEM_WORDS) * 33'd4;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          pc_legal;
  logic          can_push;
  logic          pop;
  logic          push;
  logic          flush;
  logic [CW-1:0] count;
  logic          head_vld;
  entry_t        head_dat;
  entry_t        push_dat;

  assign pc_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} < PC_LIMIT);
  assign pop      = head_vld && bus.out_ready;
  // A same-cycle pop frees a slot, so a full FIFO still streams at full rate.
  assign can_push = (count < CW'(DEPTH)) || pop;
  assign push_dat = '{pc: pc_q, instr: bus.imem_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect wins in every state; legality of the target is judged next cycle.
      flush   = 1'b1;
      pc_d    = bus.redirect_pc;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && can_push) begin
      if (pc_legal) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end else begin
        state_d = ST_HALT;
      end
    end
  end

  instr_fetch_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (flush),
    .count_o    (count),
    .head_vld_o (head_vld),
    .head_dat_o (head_dat)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = head_vld;
  assign bus.out_instr = head_dat.instr;
  assign bus.out_pc    = head_dat.pc;
  assign bus.fault     = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a 64-word combinational instruction memory model.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Prints one TB_RESULT summary line.
module tb_instr_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] mem [64];

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64),
    .DEPTH      (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory; addresses past the end alias, which is harmless here.
  assign bus.imem_rd = mem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_000A;
    mem[2] = 32'h0109_5020;
    for (int i = 3; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset values
    tick();
    tick();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_fault", {31'b0, bus.fault}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);

    // Streaming with out_ready=1 from release
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("s0_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("s0_pc", bus.out_pc, 32'h0);
    chk("s0_instr", bus.out_instr, 32'h2008_0005);
    tick();
    chk("s1_pc", bus.out_pc, 32'h4);
    chk("s1_instr", bus.out_instr, 32'h2009_000A);
    tick();
    chk("s2_pc", bus.out_pc, 32'h8);
    chk("s2_instr", bus.out_instr, 32'h0109_5020);

    // Backpressure: ready low for 5 cycles after reset
    rst_n = 1'b0;
    #1;
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("bp_addr_hold", bus.imem_addr, 32'h8);
    chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_head_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_pc4", bus.out_pc, 32'h4);
    tick();
    chk("bp_rel_pc8", bus.out_pc, 32'h8);
    chk("bp_rel_valid", {31'b0, bus.out_valid}, 32'd1);

    // Redirect to 0x4 with 0x8 and 0xC buffered, decode stalled
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4;
    tick();
    chk("rd_flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rd_addr", bus.imem_addr, 32'h4);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    tick();
    chk("rd_tgt_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("rd_tgt_pc", bus.out_pc, 32'h4);
    chk("rd_tgt_instr", bus.out_instr, 32'h2009_000A);

    // Run to the end of memory, one word per cycle
    for (int a = 8; a <= 32'hFC; a += 4) begin
      tick();
      chk("run_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("run_pc", bus.out_pc, 32'(a));
      chk("run_instr", bus.out_instr, mem[a >> 2]);
    end
    tick();
    chk("end_fault", {31'b0, bus.fault}, 32'd1);
    chk("end_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("end_addr", bus.imem_addr, 32'h100);
    tick();
    chk("end_fault_hold", {31'b0, bus.fault}, 32'd1);
    chk("end_addr_hold", bus.imem_addr, 32'h100);

    // Redirect out of HALT
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    chk("rec_fault", {31'b0, bus.fault}, 32'd0);
    chk("rec_valid0", {31'b0, bus.out_valid}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    chk("rec_valid1", {31'b0, bus.out_valid}, 32'd1);
    chk("rec_pc", bus.out_pc, 32'h0);
    chk("rec_instr", bus.out_instr, 32'h2008_0005);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    tick();
    chk("mis_valid0", {31'b0, bus.out_valid}, 32'd0);
    chk("mis_fault0", {31'b0, bus.fault}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    chk("mis_fault", {31'b0, bus.fault}, 32'd1);
    chk("mis_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mis_addr", bus.imem_addr, 32'h6);
    tick();
    chk("mis_fault_hold", {31'b0, bus.fault}, 32'd1);
    chk("mis_valid_hold", {31'b0, bus.out_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    tick();
    chk("mis_rec_fault", {31'b0, bus.fault}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    chk("mis_rec_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("mis_rec_pc", bus.out_pc, 32'h8);
    chk("mis_rec_instr", bus.out_instr, 32'h0109_5020);

    // Asynchronous reset with the FIFO full
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("full_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("full_addr", bus.imem_addr, 32'h10);
    chk("full_pc", bus.out_pc, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_fault", {31'b0, bus.fault}, 32'd0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    chk("ar_pc", bus.out_pc, 32'h0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_rel_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ar_rel_pc", bus.out_pc, 32'h0);
    chk("ar_rel_instr", bus.out_instr, 32'h2008_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
